pll_lock_sequencer: RTL and testbench

Reset/lock sequencer directly downstream of the fabric PLL wrapper. It drives the PLL's `rst` input and consumes its asynchronous `locked` output. It holds the design's system reset until lock has been stable and a hold interval has elapsed. It re-arms the PLL on loss of lock or lock timeout and declares failure after a bounded number of retries. It runs on the PLL reference clock, so it operates while the PLL outputs are absent.

---
 rtl/pll_seq_pkg.sv | 30 +++
 rtl/pll_lock_sequencer_bit_sync.sv | 29 ++
 rtl/pll_lock_sequencer.sv | 141 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encoding and counter sizing for the PLL lock/reset sequencer.
// Types and constant functions only; no latency and no backpressure.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_state_e;

    // The counter only ever holds 0..N-1 for the longest state, so clog2(N) bits suffice.
    function automatic int cnt_width(input int max_cyc);
        return (max_cyc <= 2) ? 1 : $clog2(max_cyc);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(max4(16, 65536, 1024, 256));

endpackage

// File: rtl/pll_lock_sequencer_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; clr empties the chain.
// Latency: STAGES clk edges from input to output; no backpressure.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, waits for stable lock plus a hold time, then releases sys_rst; retries and fails.
// Latency: outputs registered from next state (change on the entering edge); no backpressure.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int HOLD_CYC         = 256,
    parameter int MAX_RETRIES      = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] retry_cnt
);

    localparam int CNT_W = cnt_width(max4(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, HOLD_CYC));

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_cnt_q, retry_cnt_d;
    logic [7:0]       lock_loss_cnt_q, lock_loss_cnt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             lock_s;
    logic             sync_clr;

    // Lock seen while the PLL is held in reset is stale, so the chain is flushed for the whole pulse.
    assign sync_clr = rst || (state_q == PLL_RST);

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .clr (sync_clr),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_d         = state_q;
        retry_cnt_d     = retry_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;

        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_cnt_d = retry_cnt_q + 8'd1;
                    state_d     = (retry_cnt_q + 8'd1 == RETRY_LIMIT) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!lock_s)                   state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d     = RUN;
                    retry_cnt_d = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    if (lock_loss_cnt_q != 8'hFF) lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == RUN || state_q == FAIL) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pll_rst_d = (state_d == PLL_RST);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q         <= PLL_RST;
            cnt_q           <= '0;
            retry_cnt_q     <= '0;
            lock_loss_cnt_q <= '0;
            pll_rst_q       <= 1'b1;
            sys_rst_q       <= 1'b1;
            ready_q         <= 1'b0;
            fail_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_cnt_q     <= retry_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
            pll_rst_q       <= pll_rst_d;
            sys_rst_q       <= sys_rst_d;
            ready_q         <= ready_d;
            fail_q          <= fail_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign lock_loss_cnt = lock_loss_cnt_q;
    assign retry_cnt     = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: lock-arrival table, hand-written corner sequences,
// and randomized lock/reset activity compared every edge against a phase/timer reference model.
module tb_pll_lock_sequencer;

    localparam int SYNC = 2;
    localparam int RSTC = 4;
    localparam int TMO  = 32;
    localparam int STB  = 8;
    localparam int HLD  = 4;
    localparam int MAXR = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [7:0] lock_loss_cnt, retry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .SYNC_STAGES      (SYNC),
        .PLL_RST_CYC      (RSTC),
        .LOCK_TIMEOUT_CYC (TMO),
        .LOCK_STABLE_CYC  (STB),
        .HOLD_CYC         (HLD),
        .MAX_RETRIES      (MAXR)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .fail          (fail),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model: phases with elapsed-time bookkeeping ----------------
    typedef enum {M_PLLRST, M_WAIT, M_STABLE, M_HOLD, M_RUN, M_FAIL} mph_t;

    mph_t ph = M_PLLRST;
    int   spent = 0;
    int   m_retry = 0;
    int   m_loss = 0;
    bit   pipe[$];
    bit   m_armed = 1'b0;

    function automatic int phase_len(input mph_t p);
        case (p)
            M_PLLRST: return RSTC;
            M_WAIT:   return TMO;
            M_STABLE: return STB;
            M_HOLD:   return HLD;
            default:  return 0;
        endcase
    endfunction

    always @(posedge refclk) begin : model
        bit   seen_lock;
        bit   full;
        mph_t nxt;
        int   exp_vec, act_vec;
        if (rst) begin
            ph      = M_PLLRST;
            spent   = 0;
            m_retry = 0;
            m_loss  = 0;
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
            m_armed = 1'b1;
        end else if (m_armed) begin
            seen_lock = pipe[SYNC-1];
            if (ph == M_PLLRST) begin
                foreach (pipe[i]) pipe[i] = 1'b0;
            end else begin
                pipe.push_front(pll_locked);
                void'(pipe.pop_back());
            end
            full = (spent + 1 == phase_len(ph));
            nxt  = ph;
            case (ph)
                M_PLLRST: if (full) nxt = M_WAIT;
                M_WAIT: begin
                    if (seen_lock) nxt = M_STABLE;
                    else if (full) begin
                        m_retry = m_retry + 1;
                        nxt = (m_retry == MAXR) ? M_FAIL : M_PLLRST;
                    end
                end
                M_STABLE: if (!seen_lock) nxt = M_WAIT; else if (full) nxt = M_HOLD;
                M_HOLD: begin
                    if (!seen_lock) nxt = M_WAIT;
                    else if (full) begin nxt = M_RUN; m_retry = 0; end
                end
                M_RUN: if (!seen_lock) begin nxt = M_PLLRST; m_loss = (m_loss < 255) ? m_loss + 1 : 255; end
                default: nxt = M_FAIL;
            endcase
            spent = (nxt == ph) ? spent + 1 : 0;
            ph    = nxt;
        end
        #2;
        if (m_armed) begin
            exp_vec = {ph == M_PLLRST, ph != M_RUN, ph == M_RUN, ph == M_FAIL, m_retry[7:0], m_loss[7:0]};
            act_vec = {pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt};
            check("model_outputs", act_vec, exp_vec);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic drive(input logic lvl, input int k);
        repeat (k) begin
            pll_locked = lvl;
            tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, pll_rst, 1);
        check({tag, "_sys_rst"}, sys_rst, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_loss"}, lock_loss_cnt, 0);
        check({tag, "_retry"}, retry_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
    endtask

    // ---------------- lock-arrival table ----------------
    // lock_edge: first edge after reset release that samples pll_locked=1 (held high after).
    typedef struct {
        int lock_edge;
        int exp_ready_edge;
        int exp_fail_edge;
        int exp_retry_pre;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int r_edge, f_edge, pre, prev_retry;
        bit done;

        tbl[0] = '{1, 19, 0, 0};
        tbl[1] = '{5, 19, 0, 0};
        tbl[2] = '{12, 26, 0, 0};
        tbl[3] = '{34, 48, 0, 0};
        tbl[4] = '{35, 55, 0, 1};
        tbl[5] = '{70, 84, 0, 1};
        tbl[6] = '{71, 0, 72, 1};

        tick();
        check_reset_vals("initial");

        foreach (tbl[t]) begin
            do_reset();
            r_edge = 0; f_edge = 0; pre = -1; prev_retry = 0; done = 1'b0;
            for (int n = 1; n <= 100; n++) begin
                pll_locked = (n >= tbl[t].lock_edge);
                tick();
                if (!done && (ready || fail)) begin
                    done = 1'b1;
                    pre  = prev_retry;
                    if (ready) r_edge = n;
                    if (fail)  f_edge = n;
                end
                prev_retry = retry_cnt;
            end
            check($sformatf("tbl%0d_ready_edge", t), r_edge, tbl[t].exp_ready_edge);
            check($sformatf("tbl%0d_fail_edge", t), f_edge, tbl[t].exp_fail_edge);
            check($sformatf("tbl%0d_retry_pre", t), pre, tbl[t].exp_retry_pre);
        end

        // Stuck-low lock: two PLL reset pulses, then FAIL held until rst.
        do_reset();
        for (int n = 1; n <= 72; n++) begin
            drive(1'b0, 1);
            check($sformatf("stuck_pll_rst_e%0d", n), pll_rst, int'((n <= 3) || (n >= 36 && n <= 39)));
            check($sformatf("stuck_fail_e%0d", n), fail, int'(n >= 72));
        end
        check("stuck_retry", retry_cnt, 2);
        check("stuck_sys_rst", sys_rst, 1);
        drive(1'b1, 20);
        check("fail_sticky", fail, 1);
        check("fail_no_ready", ready, 0);
        check("fail_sys_rst", sys_rst, 1);
        check("fail_pll_rst", pll_rst, 0);
        rst = 1'b1;
        tick();
        check_reset_vals("rst_in_fail");

        // Two-cycle glitch during STABLE restarts qualification.
        do_reset();
        drive(1'b1, 8);
        drive(1'b0, 2);
        drive(1'b1, 9);
        check("glitch_no_run_e19", ready, 0);
        drive(1'b1, 5);
        check("glitch_no_run_e24", ready, 0);
        check("glitch_retry", retry_cnt, 0);
        drive(1'b1, 1);
        check("glitch_run_e25", ready, 1);
        check("glitch_sys_rst", sys_rst, 0);

        // One-cycle lock drop while running.
        drive(1'b1, 4);
        drive(1'b0, 1);
        drive(1'b1, 1);
        check("drop_still_ready", ready, 1);
        drive(1'b1, 1);
        check("drop_ready", ready, 0);
        check("drop_sys_rst", sys_rst, 1);
        check("drop_pll_rst", pll_rst, 1);
        check("drop_loss", lock_loss_cnt, 1);
        drive(1'b1, 3);
        check("drop_pll_rst_4th", pll_rst, 1);
        drive(1'b1, 1);
        check("drop_pll_rst_end", pll_rst, 0);
        drive(1'b1, 14);
        check("reacq_not_yet", ready, 0);
        drive(1'b1, 1);
        check("reacq_ready", ready, 1);
        check("reacq_retry", retry_cnt, 0);

        // Loss counter saturation.
        for (int k = 2; k <= 300; k++) begin
            drive(1'b0, 1);
            drive(1'b1, 22);
            if (k == 254 || k == 255 || k == 300)
                check($sformatf("loss_after_%0d", k), lock_loss_cnt, (k < 255) ? k : 255);
        end
        check("sat_ready", ready, 1);
        rst = 1'b1;
        tick();
        check_reset_vals("rst_in_run");

        // Reset during HOLD.
        do_reset();
        drive(1'b1, 16);
        check("hold_pll_rst", pll_rst, 0);
        rst = 1'b1;
        tick();
        check_reset_vals("rst_in_hold");

        // Randomized lock activity with occasional resets; the model checks every edge.
        do_reset();
        begin
            int cyc, lvl, len;
            cyc = 0;
            while (cyc < 4000) begin
                lvl = int'($urandom_range(0, 1));
                len = int'($urandom_range(1, (lvl != 0) ? 40 : 80));
                for (int j = 0; j < len; j++) begin
                    rst = ($urandom_range(0, 149) == 0);
                    pll_locked = lvl[0];
                    tick();
                    cyc++;
                end
            end
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
